// File: rtl/sc_scan8_sequencer.sv
// ============================================================================
// Module   : sc_scan8_sequencer
// Brief    : Round-robin 8-channel mux select sequencer. It captures the mux
//            word after a dwell time and presents it with a valid/ack handshake.
//            Optional macro SC_SCAN8_CAPTURE_ALL_EN: sample every channel and
//            ignore the request flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_scan8_sequencer #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int DWELL_CYCLES     = 4
) (
  input  logic                        SC_SCAN8_CLOCK_50,
  input  logic                        SC_SCAN8_RESET_InHigh,
  input  logic                        SC_SCAN8_enable_In,
  input  logic [7:0]                  SC_SCAN8_request_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCAN8_muxData_InBUS,
  output logic [2:0]                  SC_SCAN8_select_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] SC_SCAN8_data_OutBUS,
  output logic [2:0]                  SC_SCAN8_channel_OutBUS,
  output logic                        SC_SCAN8_valid_Out,
  input  logic                        SC_SCAN8_ack_In,
  output logic                        SC_SCAN8_wrap_Out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  localparam logic [3:0] DWELL_RELOAD = 4'(DWELL_CYCLES - 1);

`ifdef SC_SCAN8_CAPTURE_ALL_EN
  localparam logic CAPTURE_ALL = 1'b1;
`else
  localparam logic CAPTURE_ALL = 1'b0;
`endif

  state_t                      state_q, state_d;
  logic [2:0]                  ptr_q, ptr_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [NUMBER_DATAWIDTH-1:0] data_q, data_d;
  logic [2:0]                  chan_q, chan_d;
  logic                        valid_q, valid_d;
  logic                        wrap_q, wrap_d;
  logic                        advance;
  logic                        sample_req;

  assign sample_req = SC_SCAN8_request_InBUS[ptr_q] | CAPTURE_ALL;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (SC_SCAN8_enable_In) begin
          state_d = ST_SETTLE;
          cnt_d   = DWELL_RELOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (sample_req) begin
          data_d  = SC_SCAN8_muxData_InBUS;
          chan_d  = ptr_q;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          advance = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (SC_SCAN8_ack_In) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Channel completion: enable is only re-examined here and in IDLE.
    if (advance) begin
      ptr_d  = ptr_q + 3'd1;
      wrap_d = (ptr_q == 3'd7);
      if (SC_SCAN8_enable_In) begin
        state_d = ST_SETTLE;
        cnt_d   = DWELL_RELOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge SC_SCAN8_CLOCK_50 or posedge SC_SCAN8_RESET_InHigh) begin
    if (SC_SCAN8_RESET_InHigh) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      chan_q  <= 3'd0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign SC_SCAN8_select_OutBUS  = ptr_q;
  assign SC_SCAN8_data_OutBUS    = data_q;
  assign SC_SCAN8_channel_OutBUS = chan_q;
  assign SC_SCAN8_valid_Out      = valid_q;
  assign SC_SCAN8_wrap_Out       = wrap_q;

endmodule

`default_nettype wire
